// File: rtl/bus_slave_interface.sv
`default_nettype none
// ============================================================================
//  Module      : bus_slave_interface
//  Description : Responder end of the 32-bit four-phase system bus handshake.
//                Latches one command word per transaction and decodes it
//                against SLAVE_ADDRESS. When addressed it executes PING,
//                READ_REG or WRITE_REG on a local register file and returns
//                REPLY_WORDS reply words over the same handshake. When not
//                addressed it follows the reply-phase handshakes silently, so
//                those strobes are never taken as new commands.
//  Ports       : clk             - system clock
//                reset           - asynchronous, active-low reset
//                bus_handshake_1 - master request strobe
//                bus_handshake_2 - slave acknowledge (0 when not addressed)
//                bus_data_in     - command word from master
//                bus_data_out    - reply word, valid while bus_data_oe=1
//                bus_data_oe     - drive enable for bus_data_out
//                regs_out        - register file, reg i at [32i+31:32i]
//                reg_write       - one-cycle pulse on a register write
//                reg_index       - register index of last decoded command
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_slave_interface #(
    parameter logic [7:0] SLAVE_ADDRESS = 8'h01,
    parameter int         NUM_REGS      = 8,
    parameter int         REPLY_WORDS   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bus_handshake_1,
    output logic                    bus_handshake_2,
    input  logic [31:0]             bus_data_in,
    output logic [31:0]             bus_data_out,
    output logic                    bus_data_oe,
    output logic [32*NUM_REGS-1:0]  regs_out,
    output logic                    reg_write,
    output logic [3:0]              reg_index
);

    // A single reply word still needs a one-bit counter to exist.
    localparam int CW = (REPLY_WORDS > 1) ? $clog2(REPLY_WORDS) : 1;

    localparam logic [CW-1:0] c_LAST_WORD = CW'(REPLY_WORDS - 1);
    localparam logic [4:0]    c_NUM_REGS  = 5'(NUM_REGS);

    localparam logic [3:0] c_CMD_PING  = 4'd0;
    localparam logic [3:0] c_CMD_READ  = 4'd1;
    localparam logic [3:0] c_CMD_WRITE = 4'd2;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LATCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_CMD_ACK   = 4'd3;
    localparam logic [3:0] S_CMD_DONE  = 4'd4;
    localparam logic [3:0] S_RD_WAIT   = 4'd5;
    localparam logic [3:0] S_RD_DRIVE  = 4'd6;
    localparam logic [3:0] S_RD_NEXT   = 4'd7;
    localparam logic [3:0] S_SKIP_CMD  = 4'd8;
    localparam logic [3:0] S_SKIP_WAIT = 4'd9;
    localparam logic [3:0] S_SKIP_HI   = 4'd10;

    logic [3:0]    r_state;
    logic [3:0]    w_next_state;
    logic [CW-1:0] r_word_cnt;
    logic [31:0]   r_cmd;
    logic [31:0]   r_reply0;
    logic [31:0]   r_reply1;
    logic [31:0]   r_regs [NUM_REGS];
    logic          r_hs2;
    logic          r_oe;
    logic [31:0]   r_data_out;
    logic          r_reg_write;
    logic [3:0]    r_reg_index;

    // Command word fields
    logic [3:0]  w_cmd;
    logic [7:0]  w_addr;
    logic [3:0]  w_idx;
    logic [15:0] w_data16;
    logic        w_addressed;
    logic [7:0]  w_status;
    logic [31:0] w_rd_value;
    logic [31:0] w_reply1;
    logic [31:0] w_reply_sel;
    logic        w_do_write;

    assign w_cmd    = r_cmd[3:0];
    assign w_addr   = r_cmd[11:4];
    assign w_idx    = r_cmd[15:12];
    assign w_data16 = r_cmd[31:16];

    assign w_addressed = (w_addr == SLAVE_ADDRESS);

    // Illegal opcode takes precedence; the index range only matters for
    // commands that touch the register file.
    always_comb begin
        w_status = 8'd0;
        if (w_cmd > c_CMD_WRITE) begin
            w_status = 8'd1;
        end else if ((w_cmd == c_CMD_READ || w_cmd == c_CMD_WRITE) &&
                     ({1'b0, w_idx} >= c_NUM_REGS)) begin
            w_status = 8'd2;
        end
    end

    assign w_do_write = w_addressed && (w_status == 8'd0) && (w_cmd == c_CMD_WRITE);

    always_comb begin
        w_rd_value = 32'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == 4'(i)) begin
                w_rd_value = r_regs[i];
            end
        end
    end

    // Word 1 reports the register value after the operation, so a write
    // echoes the value being written rather than the old contents.
    always_comb begin
        w_reply1 = 32'd0;
        if (w_status == 8'd0) begin
            if (w_cmd == c_CMD_WRITE) begin
                w_reply1 = {16'h0000, w_data16};
            end else if (w_cmd == c_CMD_READ) begin
                w_reply1 = w_rd_value;
            end
        end
    end

    always_comb begin
        w_reply_sel = 32'd0;
        if (r_word_cnt == CW'(0)) begin
            w_reply_sel = r_reply0;
        end else if ((REPLY_WORDS > 1) && (r_word_cnt == CW'(1))) begin
            w_reply_sel = r_reply1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (bus_handshake_1)  w_next_state = S_LATCH;
            S_LATCH:                           w_next_state = S_DECODE;
            S_DECODE:    w_next_state = w_addressed ? S_CMD_ACK : S_SKIP_CMD;
            S_CMD_ACK:   if (!bus_handshake_1) w_next_state = S_CMD_DONE;
            S_CMD_DONE:                        w_next_state = S_RD_WAIT;
            S_RD_WAIT:   if (bus_handshake_1)  w_next_state = S_RD_DRIVE;
            S_RD_DRIVE:  if (!bus_handshake_1) w_next_state = S_RD_NEXT;
            S_RD_NEXT:   w_next_state = (r_word_cnt == c_LAST_WORD) ? S_IDLE : S_RD_WAIT;
            S_SKIP_CMD:  if (!bus_handshake_1) w_next_state = S_SKIP_WAIT;
            S_SKIP_WAIT: if (bus_handshake_1)  w_next_state = S_SKIP_HI;
            S_SKIP_HI: begin
                if (!bus_handshake_1) begin
                    w_next_state = (r_word_cnt == c_LAST_WORD) ? S_IDLE : S_SKIP_WAIT;
                end
            end
            default:                           w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_word_cnt  <= '0;
            r_cmd       <= 32'd0;
            r_reply0    <= 32'd0;
            r_reply1    <= 32'd0;
            r_hs2       <= 1'b0;
            r_oe        <= 1'b0;
            r_data_out  <= 32'd0;
            r_reg_write <= 1'b0;
            r_reg_index <= 4'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            r_state     <= w_next_state;
            r_reg_write <= 1'b0;

            case (r_state)
                S_LATCH: r_cmd <= bus_data_in;
                S_DECODE: begin
                    r_reg_index <= w_idx;
                    if (w_addressed) begin
                        r_reply0 <= {8'h00, w_status, r_cmd[15:0]};
                        r_reply1 <= w_reply1;
                    end
                    if (w_do_write) begin
                        r_reg_write <= 1'b1;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (w_idx == 4'(i)) begin
                                r_regs[i] <= {16'h0000, w_data16};
                            end
                        end
                    end
                end
                S_CMD_DONE: r_word_cnt <= '0;
                S_RD_NEXT: begin
                    if (r_word_cnt != c_LAST_WORD) begin
                        r_word_cnt <= r_word_cnt + CW'(1);
                    end
                end
                S_SKIP_CMD: begin
                    if (!bus_handshake_1) begin
                        r_word_cnt <= '0;
                    end
                end
                S_SKIP_HI: begin
                    if (!bus_handshake_1 && (r_word_cnt != c_LAST_WORD)) begin
                        r_word_cnt <= r_word_cnt + CW'(1);
                    end
                end
                default: ;
            endcase

            // Outputs are registered from the next state so they line up
            // with the state they belong to (Moore, no input-to-output path).
            r_hs2      <= (w_next_state == S_CMD_ACK) || (w_next_state == S_RD_DRIVE);
            r_oe       <= (w_next_state == S_RD_DRIVE);
            r_data_out <= (w_next_state == S_RD_DRIVE) ? w_reply_sel : 32'd0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
            assign regs_out[32*gi +: 32] = r_regs[gi];
        end
    endgenerate

    assign bus_handshake_2 = r_hs2;
    assign bus_data_oe     = r_oe;
    assign bus_data_out    = r_data_out;
    assign reg_write       = r_reg_write;
    assign reg_index       = r_reg_index;

endmodule
`default_nettype wire
